conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/conv_window_ctrl.sv | 166 ++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequencing for a 3x3 convolution engine.
// It loads the nine weights, streams pixels through the line buffer and
// raises mac_en on every complete window. A fixed-latency delay line
// marks the result and its coordinates at the adder-tree output.
module conv_window_ctrl #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int CW       = 5,
  parameter int PIPE_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wload_valid,
  output logic          wload_ready,
  output logic          w_we,
  output logic [3:0]    w_idx,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          win_shift,
  output logic          mac_en,
  output logic          res_valid,
  output logic [CW-1:0] res_row,
  output logic [CW-1:0] res_col,
  output logic          busy,
  output logic          done
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]    wcnt;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] dcnt;

  logic w_acc;
  logic p_acc;
  logic last_w;
  logic last_col;
  logic last_pix;
  logic drain_end;

  // The delay line carries the valid flag and output coordinates of each window
  logic [PIPE_LAT-1:0] dl_v;
  logic [CW-1:0]       dl_row [PIPE_LAT];
  logic [CW-1:0]       dl_col [PIPE_LAT];

  // Handshake and end-of-phase conditions
  always_comb begin
    w_acc     = (state == LOAD_W) && wload_valid;
    p_acc     = (state == STREAM) && pix_valid;
    last_w    = (wcnt == 4'd8);
    last_col  = (col == CW'(IMG_W - 1));
    last_pix  = last_col && (row == CW'(IMG_H - 1));
    drain_end = (dcnt == DW'(PIPE_LAT - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)            state_nxt = LOAD_W;
      LOAD_W:  if (w_acc && last_w)  state_nxt = STREAM;
      STREAM:  if (p_acc && last_pix) state_nxt = DRAIN;
      DRAIN:   if (drain_end)        state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    wload_ready = (state == LOAD_W);
    w_we        = w_acc;
    w_idx       = w_acc ? wcnt : '0;
    pix_ready   = (state == STREAM);
    win_shift   = p_acc;
    // A window is complete once two full rows and two columns precede the pixel
    mac_en      = p_acc && (row >= CW'(2)) && (col >= CW'(2));
    res_valid   = dl_v[PIPE_LAT-1];
    res_row     = dl_row[PIPE_LAT-1];
    res_col     = dl_col[PIPE_LAT-1];
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

  // Weight, raster and drain counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      row  <= '0;
      col  <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wcnt <= '0;
            row  <= '0;
            col  <= '0;
            dcnt <= '0;
          end
        end
        LOAD_W: begin
          if (w_acc) wcnt <= wcnt + 4'd1;
        end
        STREAM: begin
          if (p_acc) begin
            if (last_col) begin
              col <= '0;
              row <= last_pix ? '0 : row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result delay line, advancing every cycle regardless of pixel stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_v <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        dl_row[i] <= '0;
        dl_col[i] <= '0;
      end
    end else begin
      dl_v[0]   <= mac_en;
      dl_row[0] <= mac_en ? row - CW'(2) : '0;
      dl_col[0] <= mac_en ? col - CW'(2) : '0;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        dl_v[i]   <= dl_v[i-1];
        dl_row[i] <= dl_row[i-1];
        dl_col[i] <= dl_col[i-1];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Testbench for conv_window_ctrl at 5x5 with a 3-cycle result pipeline.
module tb_conv_window_ctrl;

  localparam int W   = 5;
  localparam int H   = 5;
  localparam int LAT = 3;
  localparam int CWT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           wload_valid;
  logic           wload_ready;
  logic           w_we;
  logic [3:0]     w_idx;
  logic           pix_valid;
  logic           pix_ready;
  logic           win_shift;
  logic           mac_en;
  logic           res_valid;
  logic [CWT-1:0] res_row;
  logic [CWT-1:0] res_col;
  logic           busy;
  logic           done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int res_count = 0;
  int last_res_cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int r;
    int c;
    int t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  conv_window_ctrl #(
    .IMG_W    (W),
    .IMG_H    (H),
    .CW       (CWT),
    .PIPE_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .wload_valid (wload_valid),
    .wload_ready (wload_ready),
    .w_we        (w_we),
    .w_idx       (w_idx),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .win_shift   (win_shift),
    .mac_en      (mac_en),
    .res_valid   (res_valid),
    .res_row     (res_row),
    .res_col     (res_col),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard side: every result is popped and matched on value and latency
  always @(negedge clk) begin
    if (mon_en) begin
      if (!pix_valid) begin
        checks++;
        if (mac_en !== 1'b0) begin
          failures++;
          $display("FAIL mac_en_stall: mac_en=%b required 0 (cycle %0d)", mac_en, cyc);
        end
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL res_unexpected: res_valid=1 (%0d,%0d) required no result (cycle %0d)",
                   res_row, res_col, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (res_row !== 3'(mon_e.r) || res_col !== 3'(mon_e.c) || cyc != mon_e.t + LAT) begin
            failures++;
            $display("FAIL res_data: got (%0d,%0d) at cycle %0d required (%0d,%0d) at cycle %0d",
                     res_row, res_col, cyc, mon_e.r, mon_e.c, mon_e.t + LAT);
          end
          res_count++;
          last_res_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_weights(input int gap);
    for (int i = 0; i < 9; i++) begin
      wload_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (w_we !== 1'b1 || w_idx !== 4'(i) || wload_ready !== 1'b1) begin
        failures++;
        $display("FAIL w_write: w_we=%b w_idx=%0d wload_ready=%b required 1/%0d/1",
                 w_we, w_idx, wload_ready, i);
      end
      @(posedge clk); #1;
      wload_valid = 1'b0;
      if (i < 8) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checks++;
          if (w_we !== 1'b0 || wload_ready !== 1'b1) begin
            failures++;
            $display("FAIL w_gap: w_we=%b wload_ready=%b required 0/1", w_we, wload_ready);
          end
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1 || wload_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stream_entry: pix_ready=%b wload_ready=%b busy=%b required 1/0/1",
               pix_ready, wload_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic stream_pixels(input bit random_stall, input int start_at, input int abort_at);
    int p = 0;
    int guard = 0;
    exp_t e;
    while (p < W * H && guard < 2000) begin
      bit v;
      bit exp_mac;
      int r;
      int c;
      r = p / W;
      c = p % W;
      v = random_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      exp_mac = v && r >= 2 && c >= 2;
      start = (p == start_at);
      pix_valid = v;
      if (exp_mac) begin
        e.r = r - 2;
        e.c = c - 2;
        e.t = cyc;
        sb.push_back(e);
      end
      @(negedge clk);
      checks++;
      if (pix_ready !== 1'b1 || win_shift !== v || mac_en !== exp_mac) begin
        failures++;
        $display("FAIL stream_px%0d: pix_ready=%b win_shift=%b mac_en=%b required 1/%b/%b",
                 p, pix_ready, win_shift, mac_en, v, exp_mac);
      end
      @(posedge clk); #1;
      start = 1'b0;
      pix_valid = 1'b0;
      if (v) p++;
      guard++;
      if (p == abort_at) break;
    end
    if (guard >= 2000) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout: accepted %0d pixels required %0d", p, W * H);
    end
  endtask

  task automatic finish_run();
    bit seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout: done=0 required 1 within 20 cycles");
    end else begin
      checks++;
      if (cyc != last_res_cyc + 1) begin
        failures++;
        $display("FAIL done_timing: done at cycle %0d required %0d", cyc, last_res_cyc + 1);
      end
    end
    checks++;
    if (res_count != (W - 2) * (H - 2) || sb.size() != 0) begin
      failures++;
      $display("FAIL res_count: got %0d results, %0d pending required %0d/0",
               res_count, sb.size(), (W - 2) * (H - 2));
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b busy=%b required 0/0", done, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic full_run(input int gap, input bit random_stall, input int start_at);
    res_count = 0;
    do_start();
    load_weights(gap);
    stream_pixels(random_stall, start_at, -1);
    finish_run();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    wload_valid = 1'b1;
    pix_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b res_valid=%b required 0/0/0",
               busy, done, res_valid);
    end
    checks++;
    if (wload_ready !== 1'b0 || w_we !== 1'b0 || w_idx !== 4'd0 || pix_ready !== 1'b0 ||
        win_shift !== 1'b0 || mac_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: wr=%b we=%b idx=%0d pr=%b ws=%b mac=%b required all 0",
               wload_ready, w_we, w_idx, pix_ready, win_shift, mac_en);
    end
    checks++;
    if (res_row !== 3'd0 || res_col !== 3'd0) begin
      failures++;
      $display("FAIL reset_coord: res_row=%0d res_col=%0d required 0/0", res_row, res_col);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    wload_valid = 1'b0;
    pix_valid = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wload_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b wload_ready=%b required 0/0", busy, wload_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    res_count = 0;
    do_start();
    load_weights(0);
    stream_pixels(1'b0, -1, 13);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort: busy=%b res_valid=%b required 0/0", busy, res_valid);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet: done=%b res_valid=%b busy=%b required 0/0/0",
                 done, res_valid, busy);
      end
      @(posedge clk); #1;
    end
    full_run(0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    full_run(0, 1'b0, -1);   // back-to-back weights, no stalls
    full_run(0, 1'b1, -1);   // random pixel stalls
    full_run(0, 1'b0, 5);    // start pulsed mid-stream
    test_reset_mid();
    full_run(2, 1'b0, -1);   // weights gapped 1 in 3
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
